// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory_interface TX channel between NUM_CH requesters and routes
// each RX response back to the channel that issued the matching read.
// A small in-order FIFO remembers {reply_wanted, channel} for every tracked
// command until its rx_done arrives.
module mem_port_arbiter #(
  parameter int NUM_CH       = 2,
  parameter int IO_BITS      = 2,
  parameter int CMD_BITS     = 4,
  parameter int TRACK_CMD    = 10,
  parameter int MAX_OUTSTAND = 3,
  parameter int ARB_MODE     = 0,
  parameter int DEFAULT_CH   = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   req_valid,
  input  logic [NUM_CH*CMD_BITS-1:0]          req_cmd,
  input  logic [NUM_CH*IO_BITS-1:0]           req_data,
  input  logic [NUM_CH-1:0]                   req_reply_wanted,
  input  logic [NUM_CH-1:0]                   req_reserve,
  output logic [NUM_CH-1:0]                   grant,
  output logic                                tx_command_valid,
  output logic [CMD_BITS-1:0]                 tx_command,
  output logic [IO_BITS-1:0]                  tx_data,
  input  logic                                tx_command_started,
  input  logic                                tx_active,
  input  logic                                tx_data_next,
  input  logic                                tx_done,
  input  logic                                rx_started,
  input  logic                                rx_active,
  input  logic                                rx_sbs_valid,
  input  logic                                rx_data_valid,
  input  logic                                rx_done,
  output logic [NUM_CH-1:0]                   ch_tx_started,
  output logic [NUM_CH-1:0]                   ch_tx_active,
  output logic [NUM_CH-1:0]                   ch_tx_data_next,
  output logic [NUM_CH-1:0]                   ch_tx_done,
  output logic [NUM_CH-1:0]                   ch_rx_started,
  output logic [NUM_CH-1:0]                   ch_rx_active,
  output logic [NUM_CH-1:0]                   ch_rx_sbs_valid,
  output logic [NUM_CH-1:0]                   ch_rx_data_valid,
  output logic [NUM_CH-1:0]                   ch_rx_done,
  output logic [$clog2(MAX_OUTSTAND+1)-1:0]   outstanding,
  output logic                                rx_orphan
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int OUT_W = $clog2(MAX_OUTSTAND + 1);
  localparam int PTR_W = (MAX_OUTSTAND > 1) ? $clog2(MAX_OUTSTAND) : 1;

  localparam logic [IDX_W-1:0]    DEF_IDX    = IDX_W'(DEFAULT_CH);
  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_CH - 1);
  localparam logic [PTR_W-1:0]    LAST_PTR   = PTR_W'(MAX_OUTSTAND - 1);
  localparam logic [OUT_W-1:0]    FULL_CNT   = OUT_W'(MAX_OUTSTAND);
  localparam logic [CMD_BITS-1:0] TRACK_CODE = CMD_BITS'(TRACK_CMD);

  // Per-channel views of the flattened request buses
  logic [CMD_BITS-1:0] cmd_arr  [NUM_CH];
  logic [IO_BITS-1:0]  data_arr [NUM_CH];

  // Arbitration state and combinational winner
  logic [IDX_W-1:0] cur_idx_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [IDX_W-1:0] rr_ptr_next;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand_idx;
  logic             found;
  logic [IDX_W-1:0] grant_idx;

  // Outstanding-response FIFO
  logic [IDX_W-1:0] fifo_ch_reg [MAX_OUTSTAND];
  logic             fifo_rw_reg [MAX_OUTSTAND];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [OUT_W-1:0] count_reg;

  logic             is_track;
  logic             full;
  logic             empty;
  logic             push_en;
  logic             pop_en;
  logic [IDX_W-1:0] head_ch;
  logic             head_rw;
  logic             route_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Winner selection: a reserving owner keeps the channel, otherwise scan
  // requesters from index 0 (fixed priority) or from rr_ptr (round-robin).
  always_comb begin
    win_idx  = DEF_IDX;
    found    = 1'b0;
    cand_idx = '0;
    if (req_reserve[cur_idx_reg]) begin
      win_idx = cur_idx_reg;
      found   = 1'b1;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (ARB_MODE == 1) begin
        cand_idx = IDX_W'((int'(rr_ptr_reg) + k) % NUM_CH);
      end else begin
        cand_idx = IDX_W'(k);
      end
      if (!found && req_valid[cand_idx]) begin
        win_idx = cand_idx;
        found   = 1'b1;
      end
    end
  end

  // The grant is frozen on the current owner for the whole transfer
  assign grant_idx   = tx_active ? cur_idx_reg : win_idx;
  assign rr_ptr_next = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  assign tx_command = cmd_arr[grant_idx];
  assign tx_data    = data_arr[grant_idx];
  assign is_track   = (tx_command == TRACK_CODE);

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);

  // A tracked command is held back while no FIFO slot is free; writes still flow
  assign tx_command_valid = req_valid[grant_idx] && !(full && is_track);

  assign pop_en  = rx_done && !empty;
  assign push_en = tx_command_started && is_track && (!full || pop_en);

  assign head_ch  = fifo_ch_reg[head_reg];
  assign head_rw  = fifo_rw_reg[head_reg];
  assign route_en = !reset && !empty && head_rw;

  assign outstanding = count_reg;
  assign rx_orphan   = !reset && rx_started && empty;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic tx_sel;
    logic rx_sel;

    assign cmd_arr[gi]  = req_cmd[gi*CMD_BITS +: CMD_BITS];
    assign data_arr[gi] = req_data[gi*IO_BITS +: IO_BITS];

    assign grant[gi] = (grant_idx == IDX_W'(gi));
    assign tx_sel    = !reset && grant[gi];
    assign rx_sel    = route_en && (head_ch == IDX_W'(gi));

    assign ch_tx_started[gi]    = tx_sel && tx_command_started;
    assign ch_tx_active[gi]     = tx_sel && tx_active;
    assign ch_tx_data_next[gi]  = tx_sel && tx_data_next;
    assign ch_tx_done[gi]       = tx_sel && tx_done;

    assign ch_rx_started[gi]    = rx_sel && rx_started;
    assign ch_rx_active[gi]     = rx_sel && rx_active;
    assign ch_rx_sbs_valid[gi]  = rx_sel && rx_sbs_valid;
    assign ch_rx_data_valid[gi] = rx_sel && rx_data_valid;
    assign ch_rx_done[gi]       = rx_sel && rx_done;
  end

  // Owner tracking and round-robin pointer advance on each command start
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_idx_reg <= DEF_IDX;
      rr_ptr_reg  <= '0;
    end else begin
      if (!tx_active) begin
        cur_idx_reg <= win_idx;
      end
      if ((ARB_MODE == 1) && tx_command_started) begin
        rr_ptr_reg <= rr_ptr_next;
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_en) begin
        tail_reg <= ptr_inc(tail_reg);
      end
      if (pop_en) begin
        head_reg <= ptr_inc(head_reg);
      end
      case ({push_en, pop_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage; contents are only meaningful below count_reg so no reset
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_ch_reg[tail_reg] <= grant_idx;
      fifo_rw_reg[tail_reg] <= req_reply_wanted[grant_idx];
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two environments (fixed priority and
// round-robin) with a memory_interface stand-in, a queue-based reference
// model and a per-cycle monitor.
module tb_mem_port_arbiter;

  localparam int NCH   = 4;
  localparam int CB    = 4;
  localparam int IOB   = 2;
  localparam int TRACK = 10;
  localparam int WR    = 5;
  localparam int MAXO  = 3;
  localparam int DEF   = 2;
  localparam int OW    = $clog2(MAXO + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   rx_rate = 0;

  always #5 clk = ~clk;

  task automatic check(input int env, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL env%0d %s: got 0x%0h expected 0x%0h at %0t",
                 env, name, act, exp, $time);
    end
  endtask

  // Owner by the arbitration rules: reserve lock, then first requester in scan order, else default
  function automatic int pick(input int mode, input int cur, input int rr,
                              input logic [NCH-1:0] v, input logic [NCH-1:0] rs);
    if (rs[cur]) return cur;
    for (int k = 0; k < NCH; k++) begin
      int c;
      c = (mode == 1) ? (rr + k) % NCH : k;
      if (v[c]) return c;
    end
    return DEF;
  endfunction

  function automatic logic [NCH-1:0] gate(input logic en, input logic [NCH-1:0] v);
    return en ? v : '0;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_env
    logic [NCH-1:0]     req_valid, req_reply_wanted, req_reserve, grant;
    logic [NCH*CB-1:0]  req_cmd;
    logic [NCH*IOB-1:0] req_data;
    logic               tx_command_valid;
    logic [CB-1:0]      tx_command;
    logic [IOB-1:0]     tx_data;
    logic tx_command_started, tx_active, tx_data_next, tx_done;
    logic rx_started, rx_active, rx_sbs_valid, rx_data_valid, rx_done;
    logic [NCH-1:0] ch_tx_started, ch_tx_active, ch_tx_data_next, ch_tx_done;
    logic [NCH-1:0] ch_rx_started, ch_rx_active, ch_rx_sbs_valid, ch_rx_data_valid, ch_rx_done;
    logic [OW-1:0]  outstanding;
    logic           rx_orphan;

    // Reference state: current owner, round-robin start, queue of pending responses
    int m_cur = DEF;
    int m_rr  = 0;
    int q_ch[$];
    bit q_rw[$];

    mem_port_arbiter #(
      .NUM_CH(NCH), .IO_BITS(IOB), .CMD_BITS(CB), .TRACK_CMD(TRACK),
      .MAX_OUTSTAND(MAXO), .ARB_MODE(gi), .DEFAULT_CH(DEF)
    ) dut (
      .clk(clk), .reset(rst),
      .req_valid(req_valid), .req_cmd(req_cmd), .req_data(req_data),
      .req_reply_wanted(req_reply_wanted), .req_reserve(req_reserve),
      .grant(grant), .tx_command_valid(tx_command_valid),
      .tx_command(tx_command), .tx_data(tx_data),
      .tx_command_started(tx_command_started), .tx_active(tx_active),
      .tx_data_next(tx_data_next), .tx_done(tx_done),
      .rx_started(rx_started), .rx_active(rx_active), .rx_sbs_valid(rx_sbs_valid),
      .rx_data_valid(rx_data_valid), .rx_done(rx_done),
      .ch_tx_started(ch_tx_started), .ch_tx_active(ch_tx_active),
      .ch_tx_data_next(ch_tx_data_next), .ch_tx_done(ch_tx_done),
      .ch_rx_started(ch_rx_started), .ch_rx_active(ch_rx_active),
      .ch_rx_sbs_valid(ch_rx_sbs_valid), .ch_rx_data_valid(ch_rx_data_valid),
      .ch_rx_done(ch_rx_done), .outstanding(outstanding), .rx_orphan(rx_orphan)
    );

    task automatic rand_req();
      bit all_on;
      all_on = ($urandom_range(3) == 0);
      for (int c = 0; c < NCH; c++) begin
        int r;
        r = $urandom_range(99);
        req_valid[c]        = all_on ? 1'b1 : ($urandom_range(99) < 55);
        req_reserve[c]      = all_on ? 1'b0 : ($urandom_range(5) == 0);
        req_reply_wanted[c] = ($urandom_range(3) != 0);
        req_cmd[c*CB +: CB] = (r < 50) ? CB'(TRACK) : (r < 85) ? CB'(WR) : CB'($urandom_range(15));
        req_data[c*IOB +: IOB] = IOB'($urandom_range(3));
      end
    endtask

    // memory_interface stand-in: starts commands it is offered, returns responses in order
    initial begin : drv
      int tx_st, tx_cnt, rx_st, rx_cnt;
      bit go;
      tx_st = 0; tx_cnt = 0; rx_st = 0; rx_cnt = 0; go = 0;
      req_valid = '0; req_reply_wanted = '0; req_reserve = '0;
      req_cmd = '0; req_data = '0;
      tx_command_started = 0; tx_active = 0; tx_data_next = 0; tx_done = 0;
      rx_started = 0; rx_active = 0; rx_sbs_valid = 0; rx_data_valid = 0; rx_done = 0;
      forever begin
        @(posedge clk);
        #1;
        tx_command_started = 0; tx_data_next = 0; tx_done = 0;
        rx_started = 0; rx_sbs_valid = 0; rx_data_valid = 0; rx_done = 0;
        if (rst) begin
          tx_active = 0; rx_active = 0; tx_st = 0; rx_st = 0;
          rand_req();
        end else begin
          if (tx_st == 0) begin
            tx_active = 0;
            if (go) begin
              tx_command_started = 1; tx_active = 1;
              tx_cnt = $urandom_range(1, 3); tx_st = 1;
            end else begin
              rand_req();
            end
          end else begin
            rand_req();
            tx_data_next = 1'($urandom_range(1));
            tx_cnt--;
            if (tx_cnt == 0) begin tx_done = 1; tx_st = 0; end
          end
          if (rx_st == 0) begin
            rx_active = 0;
            if (q_ch.size() > 0 && $urandom_range(99) < rx_rate) begin
              rx_started = 1; rx_active = 1;
              rx_cnt = $urandom_range(1, 3); rx_st = 1;
            end else if (q_ch.size() == 0 && $urandom_range(19) == 0) begin
              rx_started = 1;
            end
          end else begin
            rx_sbs_valid  = 1'($urandom_range(1));
            rx_data_valid = 1'($urandom_range(1));
            rx_cnt--;
            if (rx_cnt == 0) begin rx_done = 1; rx_st = 0; end
          end
        end
        @(negedge clk);
        go = !rst && (tx_st == 0) && !tx_active && tx_command_valid && ($urandom_range(3) != 0);
      end
    end

    // Reference model: owner/pointer updates and scoreboard push of issued reads
    initial begin : model
      int w, g;
      forever begin
        @(posedge clk);
        if (rst) begin
          m_cur = DEF; m_rr = 0;
          q_ch.delete(); q_rw.delete();
        end else begin
          w = pick(gi, m_cur, m_rr, req_valid, req_reserve);
          g = tx_active ? m_cur : w;
          if (tx_command_started && int'(req_cmd[g*CB +: CB]) == TRACK && q_ch.size() < MAXO) begin
            q_ch.push_back(g);
            q_rw.push_back(req_reply_wanted[g]);
          end
          if (tx_command_started && gi == 1) m_rr = (g + 1) % NCH;
          if (!tx_active) m_cur = w;
        end
      end
    end

    // Monitor: compare every output each cycle, pop the scoreboard on each response end
    initial begin : mon
      int w, g;
      bit empty, full, evalid;
      logic [NCH-1:0] gv, tv, hv;
      logic [CB-1:0]  ecmd;
      @(posedge clk);
      forever begin
        @(negedge clk);
        w = pick(gi, m_cur, m_rr, req_valid, req_reserve);
        g = tx_active ? m_cur : w;
        gv = '0; gv[g] = 1'b1;
        ecmd   = req_cmd[g*CB +: CB];
        empty  = (q_ch.size() == 0);
        full   = (q_ch.size() == MAXO);
        evalid = req_valid[g] && !(full && ecmd == CB'(TRACK));
        tv = rst ? '0 : gv;
        hv = '0;
        if (!rst && !empty && q_rw[0]) hv[q_ch[0]] = 1'b1;

        check(gi, "grant", grant, gv);
        check(gi, "tx_command_valid", tx_command_valid, evalid);
        check(gi, "tx_command", tx_command, ecmd);
        check(gi, "tx_data", tx_data, req_data[g*IOB +: IOB]);
        check(gi, "outstanding", outstanding, q_ch.size());
        check(gi, "rx_orphan", rx_orphan, !rst && rx_started && empty);
        check(gi, "ch_tx",
              {ch_tx_started, ch_tx_active, ch_tx_data_next, ch_tx_done},
              {gate(tx_command_started, tv), gate(tx_active, tv),
               gate(tx_data_next, tv), gate(tx_done, tv)});
        check(gi, "ch_rx",
              {ch_rx_started, ch_rx_active, ch_rx_sbs_valid, ch_rx_data_valid, ch_rx_done},
              {gate(rx_started, hv), gate(rx_active, hv), gate(rx_sbs_valid, hv),
               gate(rx_data_valid, hv), gate(rx_done, hv)});

        if (!rst && tx_command_started)
          $display("[TB] env%0d TX ch=%0d cmd=0x%0h data=%0d outstanding=%0d",
                   gi, g, ecmd, req_data[g*IOB +: IOB], q_ch.size());
        if (!rst && rx_started && empty)
          $display("[TB] env%0d RX orphan start", gi);
        if (!rst && rx_done && !empty) begin
          $display("[TB] env%0d RX ch=%0d reply=%0d", gi, q_ch[0], q_rw[0]);
          void'(q_ch.pop_front());
          void'(q_rw.pop_front());
        end
      end
    end
  end

  // Phases: fill the FIFO with no responses, normal traffic, reset mid-run, then mixed rates
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    rx_rate = 0;
    repeat (150) @(posedge clk);
    rx_rate = 50;
    repeat (400) @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst = 1'b0;
    rx_rate = 10;
    repeat (300) @(posedge clk);
    rx_rate = 60;
    repeat (400) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
